// File: rtl/spi_adc_slave.sv
// spi_adc_slave
// Device end of an SPI read link that stands in for a 4-channel, 12-bit serial
// ADC. The master shifts an 8-bit command out on MOSI. This block returns the
// selected channel's sample on MISO. Everything runs in the clk_i domain: the
// serial clock is oversampled, never used as a clock.
//
// Ports
//   clk_i        system clock, the only clock
//   rst_i        synchronous active-high reset
//   dclk_i       serial clock from the master (async, idles low)
//   cs_i         chip select, active low (async)
//   mosi_i       command bits, MSB first, master changes them on dclk falls
//   sample_i     channel samples, channel n = sample_i[12n+11:12n]
//   miso_o       response bit, updated after dclk falls
//   cmd_o        last accepted command word
//   ch_o         channel of the last accepted command (cmd_o[5:4])
//   cmd_valid_o  one-cycle pulse when a command is accepted
//   done_o       one-cycle pulse when a frame completes
//   busy_o       high while a frame is in progress (CMD or CONV)
//
// Command word: [7] start bit (must be 1), [6] ignored, [5:4] channel,
// [3] mode (0 = 12-bit, 1 = 8-bit), [2:0] don't care.
//
// state | meaning
// IDLE  | waiting for cs low while armed
// CMD   | shifting in the 8 command bits on dclk rises
// CONV  | returning the sample on dclk falls until the 24th rise
// DONE  | frame over, edges ignored, miso low until cs goes high

module spi_adc_slave (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dclk_i,
  input  logic        cs_i,
  input  logic        mosi_i,
  input  logic [47:0] sample_i,
  output logic        miso_o,
  output logic [7:0]  cmd_o,
  output logic [1:0]  ch_o,
  output logic        cmd_valid_o,
  output logic        done_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_CONV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // [0] is the first synchronizer stage, [2] the edge-compare stage.
  logic [2:0]  r_dclk_sync;
  logic [2:0]  r_cs_sync;
  logic [2:0]  r_mosi_sync;
  logic        r_rise;
  logic        r_fall;
  logic        r_armed;

  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic [6:0]  r_cmd_sr;
  logic [6:0]  w_cmd_sr_nxt;
  logic [7:0]  r_cmd;
  logic [7:0]  w_cmd_nxt;
  logic [1:0]  r_ch;
  logic [1:0]  w_ch_nxt;
  logic [11:0] r_data;
  logic [11:0] w_data_nxt;
  logic        r_miso;
  logic        w_miso_nxt;
  logic        r_cmd_valid;
  logic        w_cmd_valid_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        r_busy;

  logic        w_cs_high;
  logic        w_mosi;
  logic [7:0]  w_shift;
  logic [11:0] w_sel;
  logic [3:0]  w_bidx;
  logic        w_bit_live;
  logic        w_miso_bit;

  assign w_cs_high = r_cs_sync[2];
  assign w_mosi    = r_mosi_sync[2];
  // Command word as it will look once the current mosi bit is shifted in.
  assign w_shift   = {r_cmd_sr, w_mosi};

  // Input synchronizers and registered edge strobes. The cs chain resets to 0
  // so a cs that is already low at reset release never looks like a
  // deassertion and cannot arm the block.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dclk_sync <= 3'b000;
      r_cs_sync   <= 3'b000;
      r_mosi_sync <= 3'b000;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_dclk_sync <= {r_dclk_sync[1:0], dclk_i};
      r_cs_sync   <= {r_cs_sync[1:0], cs_i};
      r_mosi_sync <= {r_mosi_sync[1:0], mosi_i};
      r_rise      <= r_dclk_sync[1] & ~r_dclk_sync[2];
      r_fall      <= ~r_dclk_sync[1] & r_dclk_sync[2];
      if (w_cs_high) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Channel select for the snapshot, using the channel field of the command
  // being completed in this cycle.
  always_comb begin
    w_sel = sample_i[11:0];
    case (w_shift[5:4])
      2'd0: w_sel = sample_i[11:0];
      2'd1: w_sel = sample_i[23:12];
      2'd2: w_sel = sample_i[35:24];
      2'd3: w_sel = sample_i[47:36];
      default: w_sel = sample_i[11:0];
    endcase
  end

  // On a fall the counter equals the fall number. Falls 9..20 carry D11..D0,
  // i.e. bit (20 - cnt). Mod 16 that is (4 - cnt[3:0]), which stays in 0..11
  // over the live range.
  assign w_bidx     = 4'd4 - r_cnt[3:0];
  assign w_bit_live = (r_cnt >= 5'd9) && (r_cnt <= 5'd20) &&
                      !(r_cmd[3] && (r_cnt >= 5'd17));
  assign w_miso_bit = w_bit_live ? r_data[w_bidx] : 1'b0;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cmd_sr_nxt    = r_cmd_sr;
    w_cmd_nxt       = r_cmd;
    w_ch_nxt        = r_ch;
    w_data_nxt      = r_data;
    w_miso_nxt      = r_miso;
    w_cmd_valid_nxt = 1'b0;
    w_done_nxt      = 1'b0;

    // cs high beats any dclk strobe in the same cycle.
    if (w_cs_high) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 5'd0;
      w_miso_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_armed) begin
            w_state_nxt  = S_CMD;
            w_cnt_nxt    = 5'd0;
            w_cmd_sr_nxt = 7'd0;
            w_miso_nxt   = 1'b0;
          end
        end
        S_CMD: begin
          if (r_rise) begin
            w_cmd_sr_nxt = w_shift[6:0];
            w_cnt_nxt    = r_cnt + 5'd1;
            if (r_cnt == 5'd7) begin
              if (w_shift[7]) begin
                w_cmd_nxt       = w_shift;
                w_ch_nxt        = w_shift[5:4];
                w_cmd_valid_nxt = 1'b1;
                w_data_nxt      = w_sel;
                w_state_nxt     = S_CONV;
              end else begin
                w_state_nxt = S_DONE;
              end
            end
          end
        end
        S_CONV: begin
          if (r_rise) begin
            w_cnt_nxt = (r_cnt >= 5'd24) ? 5'd24 : r_cnt + 5'd1;
            if (r_cnt >= 5'd23) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_DONE;
              w_miso_nxt  = 1'b0;
            end
          end else if (r_fall) begin
            w_miso_nxt = w_miso_bit;
          end
        end
        S_DONE: begin
          w_miso_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_miso_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_cmd_sr    <= 7'd0;
      r_cmd       <= 8'h00;
      r_ch        <= 2'd0;
      r_data      <= 12'h000;
      r_miso      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd_sr    <= w_cmd_sr_nxt;
      r_cmd       <= w_cmd_nxt;
      r_ch        <= w_ch_nxt;
      r_data      <= w_data_nxt;
      r_miso      <= w_miso_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= (w_state_nxt == S_CMD) || (w_state_nxt == S_CONV);
    end
  end

  assign miso_o      = r_miso;
  assign cmd_o       = r_cmd;
  assign ch_o        = r_ch;
  assign cmd_valid_o = r_cmd_valid;
  assign done_o      = r_done;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_spi_adc_slave.sv
// Directed bench for spi_adc_slave: drives full SPI frames as the master would
// and compares the returned word, pulses and status against hand-computed
// values.

module tb_spi_adc_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        dclk;
  logic        cs;
  logic        mosi;
  logic [47:0] sample;
  logic        miso_o;
  logic [7:0]  cmd_o;
  logic [1:0]  ch_o;
  logic        cmd_valid_o;
  logic        done_o;
  logic        busy_o;

  int n_chk = 0;
  int n_err = 0;

  int n_cv = 0;
  int n_done = 0;
  int n_miso_hi = 0;
  int n_cv_long = 0;
  int n_done_long = 0;
  logic prev_cv = 1'b0;
  logic prev_done = 1'b0;

  spi_adc_slave dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .dclk_i      (dclk),
    .cs_i        (cs),
    .mosi_i      (mosi),
    .sample_i    (sample),
    .miso_o      (miso_o),
    .cmd_o       (cmd_o),
    .ch_o        (ch_o),
    .cmd_valid_o (cmd_valid_o),
    .done_o      (done_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_valid_o) n_cv++;
    if (done_o) n_done++;
    if (miso_o) n_miso_hi++;
    if (cmd_valid_o && prev_cv) n_cv_long++;
    if (done_o && prev_done) n_done_long++;
    prev_cv = cmd_valid_o;
    prev_done = done_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One master frame of 24 dclk periods. The master samples miso at each rise;
  // the returned word is what it captured on rises 10..21, extra is the OR of
  // every other captured bit.
  task automatic run_frame(input logic [7:0] cmd, input int half,
                           input int abort_at, input int rst_at,
                           input int chg_at, input logic [11:0] chg_val,
                           output logic [11:0] word, output logic extra,
                           output logic busy_mid);
    logic [24:0] cap;
    logic [7:0]  sh;
    cap = '0;
    sh = cmd;
    busy_mid = 1'b0;
    cs = 1'b0;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 24; k++) begin
      mosi = (k <= 8) ? sh[7] : 1'b0;
      sh = sh << 1;
      repeat (half) @(negedge clk);
      cap[k] = miso_o;
      dclk = 1'b1;
      if (k == 12) busy_mid = busy_o;
      if (k == chg_at) sample[23:12] = chg_val;
      if (k == abort_at) begin
        repeat (half) @(negedge clk);
        chk("busy_pre_abort", 32'(busy_o), 32'd1);
        dclk = 1'b0;
        cs = 1'b1;
        repeat (4) @(negedge clk);
        chk("busy_abort", 32'(busy_o), 32'd0);
        break;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_cmd", 32'(cmd_o), 32'h00);
        chk("rst_mid_ch", 32'(ch_o), 32'd0);
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        chk("rst_mid_miso", 32'(miso_o), 32'd0);
      end
      repeat (half) @(negedge clk);
      dclk = 1'b0;
    end
    repeat (10) @(negedge clk);
    cs = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 12; i++) word[11-i] = cap[10+i];
    extra = (|cap[9:1]) | (|cap[24:22]);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] word;
    logic        extra;
    logic        bm;
    int          cv0, d0, m0;

    rst = 1'b1;
    cs = 1'b1;
    dclk = 1'b0;
    mosi = 1'b0;
    sample = {12'hFFF, 12'h333, 12'hA5C, 12'h111};
    repeat (5) @(negedge clk);
    chk("rst_miso", 32'(miso_o), 32'd0);
    chk("rst_cmd", 32'(cmd_o), 32'h00);
    chk("rst_ch", 32'(ch_o), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Nominal 12-bit read of channel 1.
    cv0 = n_cv; d0 = n_done;
    run_frame(8'h97, 40, 0, 0, 0, 12'h000, word, extra, bm);
    chk("nom_cmd", 32'(cmd_o), 32'h97);
    chk("nom_ch", 32'(ch_o), 32'd1);
    chk("nom_cv_cnt", 32'(n_cv - cv0), 32'd1);
    chk("nom_done_cnt", 32'(n_done - d0), 32'd1);
    chk("nom_word", 32'(word), 32'hA5C);
    chk("nom_extra", 32'(extra), 32'd0);
    chk("nom_busy_mid", 32'(bm), 32'd1);
    chk("nom_busy_end", 32'(busy_o), 32'd0);

    // 8-bit mode on channel 3: eight ones then zeros.
    cv0 = n_cv; d0 = n_done;
    run_frame(8'hB8, 40, 0, 0, 0, 12'h000, word, extra, bm);
    chk("m8_cmd", 32'(cmd_o), 32'hB8);
    chk("m8_ch", 32'(ch_o), 32'd3);
    chk("m8_word", 32'(word), 32'hFF0);
    chk("m8_extra", 32'(extra), 32'd0);
    chk("m8_done_cnt", 32'(n_done - d0), 32'd1);

    // No start bit: nothing accepted, miso silent.
    cv0 = n_cv; d0 = n_done; m0 = n_miso_hi;
    run_frame(8'h17, 40, 0, 0, 0, 12'h000, word, extra, bm);
    chk("ns_cv_cnt", 32'(n_cv - cv0), 32'd0);
    chk("ns_done_cnt", 32'(n_done - d0), 32'd0);
    chk("ns_miso_hi", 32'(n_miso_hi - m0), 32'd0);
    chk("ns_cmd_keep", 32'(cmd_o), 32'hB8);
    chk("ns_busy_mid", 32'(bm), 32'd0);

    // Abort after rise 14, then a full frame with a new sample.
    cv0 = n_cv; d0 = n_done;
    run_frame(8'h97, 40, 14, 0, 0, 12'h000, word, extra, bm);
    chk("ab_cv_cnt", 32'(n_cv - cv0), 32'd1);
    chk("ab_done_cnt", 32'(n_done - d0), 32'd0);
    sample[23:12] = 12'h5A3;
    d0 = n_done;
    run_frame(8'h97, 40, 0, 0, 0, 12'h000, word, extra, bm);
    chk("ab_next_word", 32'(word), 32'h5A3);
    chk("ab_next_extra", 32'(extra), 32'd0);
    chk("ab_next_done", 32'(n_done - d0), 32'd1);

    // Reset at rise 10 with cs held low; rest of the frame is ignored.
    d0 = n_done;
    run_frame(8'h97, 40, 0, 10, 0, 12'h000, word, extra, bm);
    chk("rf_done_cnt", 32'(n_done - d0), 32'd0);
    chk("rf_cmd_after", 32'(cmd_o), 32'h00);
    cv0 = n_cv; d0 = n_done;
    run_frame(8'hA0, 40, 0, 0, 0, 12'h000, word, extra, bm);
    chk("rf_next_cmd", 32'(cmd_o), 32'hA0);
    chk("rf_next_ch", 32'(ch_o), 32'd2);
    chk("rf_next_word", 32'(word), 32'h333);
    chk("rf_next_cv", 32'(n_cv - cv0), 32'd1);
    chk("rf_next_done", 32'(n_done - d0), 32'd1);

    // Max rate (12-clk dclk period) with the sample changing mid-CONV.
    sample[23:12] = 12'h123;
    d0 = n_done;
    run_frame(8'h97, 6, 0, 0, 12, 12'h456, word, extra, bm);
    chk("snap_word", 32'(word), 32'h123);
    chk("snap_extra", 32'(extra), 32'd0);
    chk("snap_done", 32'(n_done - d0), 32'd1);

    chk("cv_width", 32'(n_cv_long), 32'd0);
    chk("done_width", 32'(n_done_long), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
